// File: rtl/mouse_ps2_pkg.sv
// Shared PS/2 mouse definitions: FSM state encoding, command bytes, default timing.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package mouse_ps2_pkg;

   // Transmitter state encoding; the receiver uses the same style of enum.
   typedef enum logic [2:0] {
      ST_IDLE         = 3'd0,
      ST_INHIBIT      = 3'd1,
      ST_RTS          = 3'd2,
      ST_SEND         = 3'd3,
      ST_WAIT_ACK     = 3'd4,
      ST_WAIT_RELEASE = 3'd5
   } mouse_tx_state_e;

   // Commands issued by the mouse master state machine.
   localparam logic [7:0] MOUSE_CMD_RESET  = 8'hFF;
   localparam logic [7:0] MOUSE_CMD_ENABLE = 8'hF4;

   // Default timing for a 100 MHz system clock.
   localparam int DEF_CLK_INHIBIT_CYCLES = 12000;   // 120 us
   localparam int DEF_TIMEOUT_CYCLES     = 200000;  // 2 ms
   localparam int DEF_CNT_W              = 18;

   // PS/2 frames carry odd parity: parity bit makes the total count of ones odd.
   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_clk_edge_detect.sv
// PS/2 clock falling-edge detector: one register stage plus a combinational pulse.
// Latency: pulse is high in the first cycle the input is seen low after being high.
// Backpressure: none; a free-running observer of the line.
module ps2_clk_edge_detect (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_ps2_clk,
   output logic o_fall
);

   logic r_ps2_clk_q;

   // Previous-cycle copy of the line; cleared so no edge is reported right after reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_ps2_clk_q <= 1'b0;
      else          r_ps2_clk_q <= i_ps2_clk;
   end

   assign o_fall = r_ps2_clk_q & ~i_ps2_clk;

endmodule

// File: rtl/mouse_transmitter.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data + odd parity + stop, ACK.
// Latency: BUSY the cycle after SEND_BYTE; BYTE_SENT/TX_ERROR pulse when the frame ends.
// Backpressure: SEND_BYTE is only honoured while BUSY=0; requests while busy are dropped.
// Build option: define MOUSE_TX_ACK_CHECK_EN to flag a device NACK as TX_ERROR.
module mouse_transmitter
   import mouse_ps2_pkg::*;
#(
   parameter int CLK_INHIBIT_CYCLES = DEF_CLK_INHIBIT_CYCLES,
   parameter int TIMEOUT_CYCLES     = DEF_TIMEOUT_CYCLES,
   parameter int CNT_W              = DEF_CNT_W
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       CLK_MOUSE_IN,
   input  logic       DATA_MOUSE_IN,
   input  logic       SEND_BYTE,
   input  logic [7:0] BYTE_TO_SEND,
   output logic       CLK_MOUSE_OUT_EN,
   output logic       DATA_MOUSE_OUT_EN,
   output logic       BUSY,
   output logic       BYTE_SENT,
   output logic       TX_ERROR
);

   localparam logic [CNT_W-1:0] LP_INH_LAST = CNT_W'(CLK_INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] LP_TIMEOUT  = CNT_W'(TIMEOUT_CYCLES);

   mouse_tx_state_e  r_state, w_state_nxt;
   logic [7:0]       r_shift, w_shift_nxt;
   logic             r_parity, w_parity_nxt;
   logic [3:0]       r_bit_cnt, w_bit_cnt_nxt;
   logic [CNT_W-1:0] r_timer, w_timer_nxt, w_timer_inc;
   logic             r_data_bit, w_data_bit_nxt;  // bit currently placed on DATA
   logic             r_err, w_err_nxt;            // NACK seen in this frame
   logic             w_fall, w_timeout;
   logic             w_clk_en, w_data_en, w_sent, w_tx_err;

   ps2_clk_edge_detect u_clk_edge (
      .i_clk     (CLK),
      .i_rst_n   (RESET),
      .i_ps2_clk (CLK_MOUSE_IN),
      .o_fall    (w_fall)
   );

   assign w_timer_inc = (&r_timer) ? r_timer : r_timer + 1'b1;
   assign w_timeout   = (r_timer == LP_TIMEOUT);

   // State and datapath registers; async reset releases both lines at once.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state    <= ST_IDLE;
         r_shift    <= '0;
         r_parity   <= 1'b0;
         r_bit_cnt  <= '0;
         r_timer    <= '0;
         r_data_bit <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_shift    <= w_shift_nxt;
         r_parity   <= w_parity_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_timer    <= w_timer_nxt;
         r_data_bit <= w_data_bit_nxt;
         r_err      <= w_err_nxt;
      end
   end

   // Next-state, datapath updates and line/status outputs.
   always_comb begin
      w_state_nxt    = r_state;
      w_shift_nxt    = r_shift;
      w_parity_nxt   = r_parity;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_timer_nxt    = w_timer_inc;
      w_data_bit_nxt = r_data_bit;
      w_err_nxt      = r_err;
      w_clk_en       = 1'b0;
      w_data_en      = 1'b0;
      w_sent         = 1'b0;
      w_tx_err       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_timer_nxt = '0;
            if (SEND_BYTE) begin
               w_shift_nxt    = BYTE_TO_SEND;
               w_parity_nxt   = odd_parity(BYTE_TO_SEND);
               w_bit_cnt_nxt  = '0;
               w_data_bit_nxt = 1'b0;
               w_err_nxt      = 1'b0;
               w_state_nxt    = ST_INHIBIT;
            end
         end
         ST_INHIBIT: begin
            w_clk_en = 1'b1;
            // Start bit is set up while the clock is still held low.
            if (r_timer == LP_INH_LAST) begin
               w_data_en   = 1'b1;
               w_timer_nxt = '0;
               w_state_nxt = ST_RTS;
            end
         end
         ST_RTS: begin
            w_data_en      = 1'b1;
            w_bit_cnt_nxt  = '0;
            w_timer_nxt    = '0;
            w_data_bit_nxt = 1'b0;
            w_state_nxt    = ST_SEND;
         end
         ST_SEND: begin
            w_data_en = ~r_data_bit;
            if (w_fall) begin
               w_timer_nxt   = '0;
               w_bit_cnt_nxt = r_bit_cnt + 4'd1;
               if (r_bit_cnt < 4'd8) begin
                  w_data_bit_nxt = r_shift[r_bit_cnt[2:0]];
               end else if (r_bit_cnt == 4'd8) begin
                  w_data_bit_nxt = r_parity;
               end else begin
                  w_data_bit_nxt = 1'b1;
                  w_state_nxt    = ST_WAIT_ACK;
               end
            end else if (w_timeout) begin
               w_data_en   = 1'b0;
               w_tx_err    = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         ST_WAIT_ACK: begin
            if (w_fall) begin
               w_timer_nxt = '0;
`ifdef MOUSE_TX_ACK_CHECK_EN
               if (DATA_MOUSE_IN) begin
                  w_tx_err  = 1'b1;
                  w_err_nxt = 1'b1;
               end
`endif
               w_state_nxt = ST_WAIT_RELEASE;
            end else if (w_timeout) begin
               w_tx_err    = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         ST_WAIT_RELEASE: begin
            if (CLK_MOUSE_IN && DATA_MOUSE_IN) begin
               w_sent      = ~r_err;
               w_state_nxt = ST_IDLE;
            end else if (w_timeout) begin
               w_tx_err    = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign CLK_MOUSE_OUT_EN  = w_clk_en;
   assign DATA_MOUSE_OUT_EN = w_data_en;
   assign BUSY              = (r_state != ST_IDLE);
   assign BYTE_SENT         = w_sent;
   assign TX_ERROR          = w_tx_err;

endmodule
